// File: rtl/seg7_scan_if.sv
// seg7_scan_if -- control and display bus of the multiplexed 7-segment scanner.
//   en         : scan enable, 0 = display off
//   load       : capture digits_in into the shadow register
//   digits_in  : packed 4-bit codes, digit i = bits [4i+3:4i], digit 0 rightmost
//   seg        : segments {a,b,c,d,e,f,g}, seg[6] = a
//   dig_sel    : one-hot digit select, bit i = digit i
//   frame_done : one-cycle pulse at the end of each full scan
// master = datapath side, slave = the scan driver.
interface seg7_scan_if #(
    parameter int NUM_DIGITS = 4
) ();
    logic                      en;
    logic                      load;
    logic [4*NUM_DIGITS-1:0]   digits_in;
    logic [6:0]                seg;
    logic [NUM_DIGITS-1:0]     dig_sel;
    logic                      frame_done;

    modport master (output en, load, digits_in, input seg, dig_sel, frame_done);
    modport slave  (input en, load, digits_in, output seg, dig_sel, frame_done);
endinterface

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver -- time-multiplexed driver for NUM_DIGITS common-select
// 7-segment digits. Each digit is lit for REFRESH_DIV cycles, followed by a
// one-cycle blank gap so the previous digit's segments never ghost onto the next.
// Ports:
//   clk : system clock, rising edge
//   rst : synchronous active-high reset (priority over load and en)
//   bus : seg7_scan_if.slave (en, load, digits_in in; seg, dig_sel, frame_done out)
// Optional macro SEG7_LZB_EN: leading-zero blanking of digits above digit 0.
// All outputs are registered and lag the state that produced them by one cycle.
module seg7_scan_driver #(
    parameter int NUM_DIGITS     = 4,
    parameter int REFRESH_DIV    = 1000,
    parameter int HEX_MODE       = 1,
    parameter int SEG_ACTIVE_LOW = 0
) (
    input  logic         clk,
    input  logic         rst,
    seg7_scan_if.slave   bus
);
    localparam int CNT_W = $clog2(REFRESH_DIV);
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [6:0]            SEG_OFF  = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
    localparam logic [NUM_DIGITS-1:0] DIG_OFF  = (SEG_ACTIVE_LOW != 0) ? {NUM_DIGITS{1'b1}}
                                                                       : {NUM_DIGITS{1'b0}};
    localparam logic [CNT_W-1:0]      CNT_LAST = CNT_W'(REFRESH_DIV - 1);
    localparam logic [IDX_W-1:0]      IDX_LAST = IDX_W'(NUM_DIGITS - 1);

    typedef enum logic [1:0] {IDLE, SHOW, GAP} state_t;

    state_t                         state;
    logic [CNT_W-1:0]               cnt;
    logic [IDX_W-1:0]               idx;
    logic [NUM_DIGITS-1:0][3:0]     shadow;
    logic [6:0]                     seg_q;
    logic [NUM_DIGITS-1:0]          dig_q;
    logic                           fd_q;

    logic [6:0]                     cur_seg;   // active-high pattern for digit idx
    logic [NUM_DIGITS-1:0]          cur_dig;   // active-high one-hot for digit idx

    function automatic logic [6:0] decode(input logic [3:0] code);
        logic [6:0] s;
        case (code)
            4'd0:  s = 7'b1111110;
            4'd1:  s = 7'b0110000;
            4'd2:  s = 7'b1101101;
            4'd3:  s = 7'b1111001;
            4'd4:  s = 7'b0110011;
            4'd5:  s = 7'b1011011;
            4'd6:  s = 7'b1011111;
            4'd7:  s = 7'b1110000;
            4'd8:  s = 7'b1111111;
            4'd9:  s = 7'b1111011;
            4'd10: s = 7'b1110111;
            4'd11: s = 7'b0011111;
            4'd12: s = 7'b1001110;
            4'd13: s = 7'b0111101;
            4'd14: s = 7'b1001111;
            default: s = 7'b1000111;
        endcase
        // Without hex support, codes above 9 blank the digit but keep it selected.
        if (HEX_MODE == 0 && code > 4'd9)
            s = 7'b0000000;
        return s;
    endfunction

`ifdef SEG7_LZB_EN
    // lz_blank[i] is set when digit i and every digit above it hold code 0.
    // Digit 0 is never blanked, so a value of zero still shows a single "0".
    logic [NUM_DIGITS-1:0] lz_blank;
    logic                  all_zero;
    always_comb begin
        lz_blank = '0;
        all_zero = 1'b1;
        for (int i = NUM_DIGITS - 1; i > 0; i--) begin
            all_zero    = all_zero & (shadow[i] == 4'd0);
            lz_blank[i] = all_zero;
        end
    end
    assign cur_seg = lz_blank[idx] ? 7'b0000000 : decode(shadow[idx]);
`else
    assign cur_seg = decode(shadow[idx]);
`endif

    assign cur_dig = NUM_DIGITS'(1) << idx;

    always_ff @(posedge clk) begin
        if (rst) begin
            shadow <= '0;
            idx    <= '0;
            cnt    <= '0;
            state  <= IDLE;
            seg_q  <= SEG_OFF;
            dig_q  <= DIG_OFF;
            fd_q   <= 1'b0;
        end else begin
            if (bus.load)
                shadow <= bus.digits_in;

            // Outputs are off unless the SHOW branch lights a digit this edge.
            seg_q <= SEG_OFF;
            dig_q <= DIG_OFF;
            fd_q  <= 1'b0;

            if (!bus.en) begin
                state <= IDLE;
                idx   <= '0;
                cnt   <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        state <= SHOW;
                        idx   <= '0;
                        cnt   <= '0;
                    end
                    SHOW: begin
                        seg_q <= SEG_OFF ^ cur_seg;
                        dig_q <= DIG_OFF ^ cur_dig;
                        if (cnt == CNT_LAST) begin
                            cnt   <= '0;
                            state <= GAP;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    GAP: begin
                        // The registered pulse lands in the blank cycle after the last digit.
                        fd_q  <= (idx == IDX_LAST);
                        idx   <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
                        state <= SHOW;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign bus.seg        = seg_q;
    assign bus.dig_sel    = dig_q;
    assign bus.frame_done = fd_q;

endmodule
